// File: rtl/arm_controller_pkg.sv
// Shared encodings for the single-cycle ARM controller: opcode classes,
// ALU operation select and condition-field mnemonics.
package arm_controller_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0] RD_PC = 4'hF;

endpackage

// File: rtl/arm_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the controller.
interface arm_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemWrite;
  logic        MemtoReg;
  logic        PCSrc;

  modport master (
    output Instr, ALUFlags,
    input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc
  );

  modport slave (
    input  Instr, ALUFlags,
    output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc
  );
endinterface

// File: rtl/arm_controller_condlogic.sv
// Condition evaluation against the stored NZCV flags, gating of architectural
// side effects, and the flag register itself.
module arm_controller_condlogic
  import arm_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~(c & ~z);
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = ~(~z & (n == v));
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // A failed condition blocks flag updates just like writes and branches.
  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] & cond_ex) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign pc_src    = pcs   & cond_ex;
  assign reg_write = reg_w & cond_ex;
  assign mem_write = mem_w & cond_ex;

endmodule

// File: rtl/arm_controller_decoder.sv
// Combinational main/ALU decode: ungated control strobes, operand selects,
// ALU operation and flag-write enables.
module arm_controller_decoder
  import arm_controller_pkg::*;
(
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic      branch;
  logic      alu_op;
  alu_ctrl_e alu_sel;

  always_comb begin
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    imm_src    = 2'b00;
    reg_src    = 2'b00;
    alu_op     = 1'b0;
    case (op_e'(op))
      OP_DP: begin
        reg_w   = 1'b1;
        alu_op  = 1'b1;
        alu_src = funct[5];
      end
      OP_MEM: begin
        alu_src = 1'b1;
        imm_src = 2'b01;
        if (funct[0]) begin
          mem_to_reg = 1'b1;
          reg_w      = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = 2'b10;
        end
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_src = 1'b1;
        imm_src = 2'b10;
        reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  // Unrecognised data-processing functions fall back to ADD.
  always_comb begin
    alu_sel = ALU_ADD;
    flag_w  = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: alu_sel = ALU_ADD;
        4'b0010: alu_sel = ALU_SUB;
        4'b0000: alu_sel = ALU_AND;
        4'b1100: alu_sel = ALU_ORR;
        default: alu_sel = ALU_ADD;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((alu_sel == ALU_ADD) | (alu_sel == ALU_SUB));
    end
  end

  assign alu_control = alu_sel;
  assign pcs         = branch | (reg_w & (rd == RD_PC));

endmodule

// File: rtl/arm_controller.sv
// Single-cycle ARM control unit: decoder plus conditional-execution logic.
module arm_controller
  import arm_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  arm_controller_if.slave  bus
);

  logic       pcs, reg_w, mem_w;
  logic [1:0] flag_w;
  logic       pc_src, reg_write, mem_write;
  logic       mem_to_reg, alu_src;
  logic [1:0] imm_src, reg_src, alu_control;
  logic       unused_rn;

  // Rn (original bits [19:16]) is a datapath field the controller never needs.
  assign unused_rn = ^bus.Instr[7:4];

  arm_controller_decoder u_dec (
    .op          (bus.Instr[15:14]),
    .funct       (bus.Instr[13:8]),
    .rd          (bus.Instr[3:0]),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .alu_control (alu_control),
    .flag_w      (flag_w)
  );

  arm_controller_condlogic u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Instr[19:16]),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write)
  );

  assign bus.RegSrc     = reg_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUSrc     = alu_src;
  assign bus.ALUControl = alu_control;
  assign bus.MemWrite   = mem_write;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.PCSrc      = pc_src;

endmodule

// File: tb/tb_arm_controller.sv
// Scoreboard bench for arm_controller: directed scenarios then random
// instructions, checked against an instruction-level reference model.
module tb_arm_controller;

  logic clk;
  logic reset;
  arm_controller_if bus();

  arm_controller dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [11:0] exp;
    logic [19:0] ins;
  } sb_t;

  sb_t        sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_flags;

  // Conditions come in complementary pairs: even code tests a base predicate,
  // odd code its inverse; 0xE/0xF are always/never.
  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic apply(input logic [19:0] ins, input logic [3:0] af, input logic rst);
    logic [1:0] op, regsrc, imm, aluc;
    logic [5:0] fn;
    logic       ok, regw, memw, m2r, alusrc, br, setf;
    sb_t        e;
    op = ins[15:14]; fn = ins[13:8];
    ok = cond_holds(ins[19:16], m_flags);
    regsrc = 0; imm = 0; aluc = 0; regw = 0; memw = 0; m2r = 0; alusrc = 0; br = 0; setf = 0;
    if (op == 2'd0) begin
      regw = 1; alusrc = fn[5]; setf = fn[0];
      if (fn[4:1] == 4'b0010) aluc = 2'd1;
      else if (fn[4:1] == 4'b0000) aluc = 2'd2;
      else if (fn[4:1] == 4'b1100) aluc = 2'd3;
    end else if (op == 2'd1) begin
      alusrc = 1; imm = 2'd1;
      if (fn[0]) begin m2r = 1; regw = 1; end
      else begin memw = 1; regsrc = 2'd2; end
    end else if (op == 2'd2) begin
      br = 1; alusrc = 1; imm = 2'd2; regsrc = 2'd1;
    end
    e.ins = ins;
    e.exp = {regsrc, regw & ok, imm, alusrc, aluc, memw & ok, m2r,
             (br | (regw && ins[3:0] == 4'hF)) & ok};
    bus.Instr = ins; bus.ALUFlags = af; reset = rst;
    sb_q.push_back(e);
    if (rst) m_flags = 4'b0000;
    else if (ok && setf) begin
      m_flags[3:2] = af[3:2];
      if (aluc <= 2'd1) m_flags[1:0] = af[1:0];
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  initial begin
    sb_t        e;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act = {bus.RegSrc, bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.ALUControl,
               bus.MemWrite, bus.MemtoReg, bus.PCSrc};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL ctrl instr=%05h got=%03h expected=%03h (RegSrc,RegWrite,ImmSrc,ALUSrc,ALUControl,MemWrite,MemtoReg,PCSrc)",
                   e.ins, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [19:0] ins;
    reset = 1'b1; bus.Instr = '0; bus.ALUFlags = '0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    apply(20'hE0821, 4'b0000, 1'b0);   // ADD R1,R2,R3
    apply(20'h0A000, 4'b0000, 1'b0);   // BEQ not taken after reset
    apply(20'h1A000, 4'b0000, 1'b0);   // BNE taken after reset
    apply(20'hE2510, 4'b0100, 1'b0);   // SUBS sets Z
    apply(20'h0A000, 4'b0000, 1'b0);   // BEQ now taken
    apply(20'hE5801, 4'b0000, 1'b0);   // STR
    apply(20'hE590F, 4'b0000, 1'b0);   // LDR PC
    apply(20'h10821, 4'b0000, 1'b0);   // ADDNE fails
    apply(20'h12510, 4'b0000, 1'b0);   // SUBSNE fails, no flag update
    apply(20'h0A000, 4'b0000, 1'b0);   // BEQ still taken
    apply(20'hE1901, 4'b1011, 1'b0);   // ORRS: only N,Z load
    apply(20'h4A000, 4'b0000, 1'b0);   // MI
    apply(20'h2A000, 4'b0000, 1'b0);   // CS keeps old C=0
    apply(20'hE2510, 4'b1111, 1'b0);   // SUBS -> flags 1111
    apply(20'h6A000, 4'b0000, 1'b0);   // VS taken
    apply(20'hE2510, 4'b1111, 1'b1);   // reset wins over flag load
    apply(20'h0A000, 4'b0000, 1'b0);
    apply(20'h2A000, 4'b0000, 1'b0);
    apply(20'h4A000, 4'b0000, 1'b0);
    apply(20'h6A000, 4'b0000, 1'b0);
    apply(20'h1A000, 4'b0000, 1'b0);
    apply(20'hFA000, 4'b0000, 1'b0);   // NV never executes
    for (int i = 0; i < 600; i++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 2) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 7) == 0) ins[3:0] = 4'hF;
      apply(ins, 4'($urandom), ($urandom_range(0, 31) == 0));
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_controller.md
ARM_CONTROLLER -- requirements
Module: arm_controller

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 Instr  in  20  instruction bits [31:12]: [31:28] Cond, [27:26] Op, [25:20] Funct, [15:12] Rd.
REQ-005 ALUFlags  in  4  current ALU result flags {N,Z,C,V} ([3]=N ... [0]=V).
REQ-006 RegSrc  out  2  register-address source select.
REQ-007 RegWrite  out  1  register-file write enable, condition-gated.
REQ-008 ImmSrc  out  2  immediate extend select.
REQ-009 ALUSrc  out  1  1 = immediate operand B.
REQ-010 ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-011 MemWrite  out  1  data-memory write enable, condition-gated.
REQ-012 MemtoReg  out  1  1 = result from memory.
REQ-013 PCSrc  out  1  1 = PC loaded from result, condition-gated.

Function
REQ-014 Main decode (all combinational) as Branch/MemtoReg/MemW/ALUSrc/ImmSrc/RegW/RegSrc/ALUOp: Op=00,Funct[5]=0: 0/0/0/0/00/1/00/1; Op=00,Funct[5]=1: 0/0/0/1/00/1/00/1; Op=01,Funct[0]=0 (STR): 0/0/1/1/01/0/10/0; Op=01,Funct[0]=1 (LDR): 0/1/0/1/01/1/00/0; Op=10 (B): 1/0/0/1/10/0/01/0; Op=11: all zero.
REQ-015 ALUOp=1: Funct[4:1] 0100->00, 0010->01, 0000->10, 1100->11, any other ->00.
REQ-016 ALUOp=1: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] AND ALUControl in {00,01}. ALUOp=0: ALUControl=00, FlagW=00.
REQ-017 PCS = Branch OR (RegW AND Rd==4'hF).
REQ-018 CondEx from Cond and registered flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)); E AL 1; F 0.
REQ-019 PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx; same-cycle combinational.
REQ-020 Flag register {N,Z} loads ALUFlags[3:2] on clk edge when FlagW[1]&CondEx; {C,V} loads ALUFlags[1:0] when FlagW[0]&CondEx; otherwise holds.
REQ-021 CondEx uses pre-edge stored flags; a flag-setting instruction affects only later instructions.
REQ-022 Failed condition SHALL suppress flag update as well as writes/branch.

Reset
REQ-023 reset high at clk edge clears stored flags to 0000; reset has priority over flag load.
REQ-024 Outputs have no reset value of their own; combinational from Instr and stored flags (after reset EQ fails, NE passes).

Structure
REQ-025 Shared package holds Op codes, ALUControl encodings, Cond encodings.
REQ-026 Sub-modules decoder (REQ-014..017) and condlogic (REQ-018..023); top only wires them.

Verification
REQ-027 After reset, Instr=0xE0821 (ADD R1,R2,R3) -> RegWrite=1, ALUControl=00, ALUSrc=0, RegSrc=00, ImmSrc=00, MemWrite=0, MemtoReg=0, PCSrc=0.
REQ-028 After reset, Instr=0x0A000 (BEQ) -> PCSrc=0; then Instr=0xE2510 (SUBS R0,R1,#imm), ALUFlags=0100 -> ALUControl=01, ALUSrc=1; one edge; BEQ -> PCSrc=1, ImmSrc=10, RegSrc=01, ALUSrc=1.
REQ-029 Instr=0xE5801 (STR) -> MemWrite=1, RegWrite=0, ImmSrc=01, ALUSrc=1, RegSrc=10; Instr=0xE590F (LDR PC) -> RegWrite=1, MemtoReg=1, PCSrc=1.
REQ-030 Z flag set; Instr=0x10821 (ADDNE) -> RegWrite=0; Instr=0x12510 (SUBSNE) with ALUFlags=0000, one edge -> flags stay 0100 (BEQ still taken).
REQ-031 Flags=1111, reset asserted one edge with a flag-setting Instr -> flags 0000.
